// File: rtl/hex_digit_counter.sv
// rtl/hex_digit_counter.sv - debounced up/down hex digit counter; AUTO_COUNT_EN adds prescaled auto-count
module hex_digit_counter #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_STEP,
  input  logic [3:0] SW,
  input  logic       LOAD,
  input  logic       DIR,
  input  logic       RUN,
  output logic [3:0] COUNT,
  output logic       WRAP
);

  localparam int P  = CLK_HZ / TICK_HZ;
  localparam int PW = (P > 2) ? $clog2(P) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PSC_LAST = PW'(P - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  logic       key_meta, key_s;
  logic [3:0] sw_meta, sw_s;
  logic [2:0] ctl_meta, ctl_s;
  logic       load_s, dir_s, run_s;

  assign load_s = ctl_s[2];
  assign dir_s  = ctl_s[1];
  assign run_s  = ctl_s[0];

  // Two-flop synchronizers; the key idles high (released), everything else low.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
      sw_meta  <= 4'h0;
      sw_s     <= 4'h0;
      ctl_meta <= 3'b000;
      ctl_s    <= 3'b000;
    end else begin
      key_meta <= KEY_STEP;
      key_s    <= key_meta;
      sw_meta  <= SW;
      sw_s     <= sw_meta;
      ctl_meta <= {LOAD, DIR, RUN};
      ctl_s    <= ctl_meta;
    end
  end

  db_state_t       state, state_d;
  logic [DW-1:0]   db_cnt, db_cnt_d;
  logic            step;

  // Debounce state and stability counter registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= RELEASED;
      db_cnt <= '0;
    end else begin
      state  <= state_d;
      db_cnt <= db_cnt_d;
    end
  end

  // Debounce next-state: a level change is accepted only after it holds for DEBOUNCE_CYCLES.
  always_comb begin
    state_d  = state;
    db_cnt_d = db_cnt;
    step     = 1'b0;
    case (state)
      RELEASED: begin
        if (!key_s) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = RELEASED;
        end else if (db_cnt == DB_LAST) begin
          state_d = PRESSED;
          step    = 1'b1;
        end else begin
          db_cnt_d = db_cnt + DW'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_d = RELEASED;
        end else begin
          db_cnt_d = db_cnt + DW'(1);
        end
      end
      default: begin
        state_d  = RELEASED;
        db_cnt_d = '0;
      end
    endcase
  end

  logic tick;

`ifdef AUTO_COUNT_EN
  logic [PW-1:0] psc;

  // Prescaler: registered tick one cycle after the terminal count; parked at 0 when idle or loading.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      psc  <= '0;
      tick <= 1'b0;
    end else if (!run_s || load_s) begin
      psc  <= '0;
      tick <= 1'b0;
    end else if (psc == PSC_LAST) begin
      psc  <= '0;
      tick <= 1'b1;
    end else begin
      psc  <= psc + PW'(1);
      tick <= 1'b0;
    end
  end
`else
  logic unused_auto;

  assign tick        = 1'b0;
  assign unused_auto = run_s ^ PSC_LAST[0];
`endif

  logic advance;
  assign advance = step | tick;

  // Digit register: load beats step/tick; a coincident step and tick advance only once.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT <= 4'h0;
      WRAP  <= 1'b0;
    end else if (load_s) begin
      COUNT <= sw_s;
      WRAP  <= 1'b0;
    end else if (advance) begin
      if (dir_s) begin
        COUNT <= COUNT + 4'd1;
        WRAP  <= (COUNT == 4'hF);
      end else begin
        COUNT <= COUNT - 4'd1;
        WRAP  <= (COUNT == 4'h0);
      end
    end else begin
      WRAP <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_digit_counter.sv
// tb/tb_hex_digit_counter.sv - self-checking bench for hex_digit_counter
module tb_hex_digit_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic [3:0] sw;
  logic       load;
  logic       dir;
  logic       run;
  logic [3:0] count;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_digit_counter #(
    .CLK_HZ(8),
    .TICK_HZ(1),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .KEY_STEP(key),
    .SW(sw),
    .LOAD(load),
    .DIR(dir),
    .RUN(run),
    .COUNT(count),
    .WRAP(wrap)
  );

  typedef struct {
    string      name;
    logic       key;
    logic [3:0] sw;
    logic       load;
    logic       dir;
    int         cycles;
    logic [3:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[9];

  // Advance to 1 time unit after the next rising edge.
  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) step_edge();
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 1'b1;
    sw    = 4'h0;
    load  = 1'b0;
    dir   = 1'b1;
    run   = 1'b0;

    vecs[0] = '{"load_3",    1'b1, 4'h3, 1'b1, 1'b1, 4,  4'h3, 1'b0};
    vecs[1] = '{"press_up",  1'b0, 4'h3, 1'b0, 1'b1, 10, 4'h4, 1'b0};
    vecs[2] = '{"release",   1'b1, 4'h3, 1'b0, 1'b1, 10, 4'h4, 1'b0};
    vecs[3] = '{"press_dn",  1'b0, 4'h3, 1'b0, 1'b0, 10, 4'h3, 1'b0};
    vecs[4] = '{"release2",  1'b1, 4'h3, 1'b0, 1'b0, 10, 4'h3, 1'b0};
    vecs[5] = '{"load_a",    1'b1, 4'hA, 1'b1, 1'b1, 4,  4'hA, 1'b0};
    vecs[6] = '{"sw_no_ld",  1'b1, 4'h5, 1'b0, 1'b1, 4,  4'hA, 1'b0};
    vecs[7] = '{"press_up2", 1'b0, 4'h5, 1'b0, 1'b1, 10, 4'hB, 1'b0};
    vecs[8] = '{"release3",  1'b1, 4'h5, 1'b0, 1'b1, 10, 4'hB, 1'b0};

    // Reset state
    wait_edges(3);
    chk("rst_count", count, 4'h0);
    chk("rst_wrap", {3'b0, wrap}, 4'h0);
    rst_n = 1'b1;
    wait_edges(4);
    chk("post_rst_count", count, 4'h0);

    // Debounced step: key driven low after edge 0, COUNT must change on edge 7 only
    key = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step_edge();
      chk($sformatf("step_e%0d", e), count, (e >= 7) ? 4'h1 : 4'h0);
    end
    key = 1'b1;
    wait_edges(10);

    // Short glitch is ignored
    key = 1'b0;
    wait_edges(3);
    key = 1'b1;
    wait_edges(12);
    chk("glitch", count, 4'h1);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      key  = vecs[i].key;
      sw   = vecs[i].sw;
      load = vecs[i].load;
      dir  = vecs[i].dir;
      wait_edges(vecs[i].cycles);
      chk({vecs[i].name, "_count"}, count, vecs[i].exp_count);
      chk({vecs[i].name, "_wrap"}, {3'b0, wrap}, {3'b0, vecs[i].exp_wrap});
    end

    // Load overrides a step landing in the same window
    key = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step_edge();
      chk($sformatf("ldpri_e%0d", e), count, (e >= 6) ? 4'hE : 4'hB);
      if (e == 3) begin
        sw   = 4'hE;
        load = 1'b1;
      end
      if (e == 9) load = 1'b0;
    end
    key = 1'b1;
    wait_edges(10);
    chk("ldpri_after", count, 4'hE);

    // Load F, no wrap from loading
    sw   = 4'hF;
    load = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step_edge();
      chk($sformatf("ldF_wrap_e%0d", e), {3'b0, wrap}, 4'h0);
    end
    load = 1'b0;
    wait_edges(3);
    chk("ldF_count", count, 4'hF);

    // Wrap up F -> 0
    dir = 1'b1;
    key = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step_edge();
      chk($sformatf("wrapup_cnt_e%0d", e), count, (e >= 7) ? 4'h0 : 4'hF);
      chk($sformatf("wrapup_w_e%0d", e), {3'b0, wrap}, (e == 7) ? 4'h1 : 4'h0);
    end
    key = 1'b1;
    wait_edges(10);

    // Wrap down 0 -> F
    dir = 1'b0;
    wait_edges(3);
    key = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step_edge();
      chk($sformatf("wrapdn_cnt_e%0d", e), count, (e >= 7) ? 4'hF : 4'h0);
      chk($sformatf("wrapdn_w_e%0d", e), {3'b0, wrap}, (e == 7) ? 4'h1 : 4'h0);
    end
    key = 1'b1;
    wait_edges(10);

    // Load 0 from F never wraps
    sw   = 4'h0;
    load = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step_edge();
      chk($sformatf("ld0_cnt_e%0d", e), count, (e >= 3) ? 4'h0 : 4'hF);
      chk($sformatf("ld0_wrap_e%0d", e), {3'b0, wrap}, 4'h0);
    end
    load = 1'b0;
    dir  = 1'b1;
    wait_edges(3);

`ifdef AUTO_COUNT_EN
    // Auto-count: +1 on edges 11, 19, 27, 35; key step also lands on edge 27
    run = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      step_edge();
      chk($sformatf("auto_e%0d", e), count,
          4'((e >= 11) + (e >= 19) + (e >= 27) + (e >= 35)));
      if (e == 20) key = 1'b0;
    end
    run = 1'b0;
    key = 1'b1;
    wait_edges(10);
    chk("auto_stop", count, 4'h4);
`else
    // Without auto-count RUN has no effect
    run = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step_edge();
      chk($sformatf("norun_e%0d", e), count, 4'h0);
    end
    run = 1'b0;
    wait_edges(3);
`endif

    // Asynchronous reset mid-cycle with COUNT = 7
    sw   = 4'h7;
    load = 1'b1;
    wait_edges(4);
    load = 1'b0;
    wait_edges(3);
    chk("pre_async_count", count, 4'h7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 4'h0);
    chk("async_rst_wrap", {3'b0, wrap}, 4'h0);
    wait_edges(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step_edge();
      chk($sformatf("post_async_e%0d", e), count, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_digit_counter.md
# hex_digit_counter

- 4-bit up/down hex counter whose value drives the board's seven-segment digit decoder: COUNT connects directly to the decoder's 4-bit input.
- The count steps on a debounced KEY press, loads from SW, and optionally free-runs from a prescaled tick.
- Sits between the raw board inputs (switches, pushbutton) and the display path.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, auto-count step rate; divider period P = CLK_HZ/TICK_HZ cycles, P ≥ 2.
- DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required to accept a KEY level change (≥ 1).

Ports:
- CLOCK_50  in  1  sole clock, rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY_STEP  in  1  raw pushbutton, active-low, asynchronous to CLOCK_50.
- SW  in  4  load value, asynchronous.
- LOAD  in  1  level; when high, COUNT follows SW.
- DIR  in  1  1 = count up, 0 = count down.
- RUN  in  1  enables auto-count (see Configuration).
- COUNT  out  4  current digit, to the seven-segment decoder.
- WRAP  out  1  one-cycle pulse on F→0 (up) or 0→F (down).

## Operation
- All inputs (KEY_STEP, SW, LOAD, DIR, RUN) pass through 2-flop synchronizers; all logic below uses the synchronized copies.
- Debounce FSM on synced KEY_STEP, with a counter `db_cnt`:
  - RELEASED: key low → PRESS_WAIT, clear db_cnt.
  - PRESS_WAIT:
    - key high → RELEASED.
    - Otherwise increment db_cnt; at DEBOUNCE_CYCLES-1 → PRESSED and emit internal `step` for one cycle.
  - PRESSED: key high → RELEASE_WAIT, clear db_cnt.
  - RELEASE_WAIT:
    - key low → PRESSED.
    - Otherwise increment; at DEBOUNCE_CYCLES-1 → RELEASED.
  - Exactly one `step` per accepted press. Holding the key gives no repeat. Bounces shorter than DEBOUNCE_CYCLES produce nothing.
- Prescaler counts 0..P-1 and emits internal `tick` at P-1, then wraps to 0. It is held at 0 while RUN=0 or LOAD=1.
- Counter update priority, evaluated each cycle:
  1. LOAD → COUNT = SW.
  2. `step` → COUNT ± 1 per DIR.
  3. `tick` → COUNT ± 1 per DIR.
- A step and a tick in the same cycle produce a single increment; the tick is dropped.
- Arithmetic is modulo 16. WRAP=1 in the cycle after COUNT changes F→0 (up) or 0→F (down) due to a step or tick. Loads never assert WRAP.
- DIR is sampled in the cycle the step or tick is applied.

## Timing
- Reset (RESET_N low, asynchronous):
  - COUNT=0, WRAP=0, FSM=RELEASED, db_cnt=0, prescaler=0, all synchronizer flops at idle values: KEY=1, others 0.
  - Reset is effective mid-debounce or mid-count; no step is emitted after release for a press already in progress until a full new debounce completes.
- KEY latency: if the raw key is held low from edge 0, COUNT updates on edge DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES + 1 register).
- LOAD latency: COUNT = SW on the 3rd edge after LOAD and SW are stable high/valid. While LOAD stays high, COUNT tracks SW with the same 3-cycle latency, and steps are discarded.
- Auto-count: first increment P+3 edges after RUN rises; thereafter every P cycles.
- WRAP: registered, high for exactly one cycle, aligned with the cycle in which the new COUNT is visible.

## Configuration
- AUTO_COUNT_EN defined: prescaler and RUN path compiled in, behaviour as above.
- AUTO_COUNT_EN undefined:
  - Prescaler logic absent; `tick` is constant 0.
  - RUN port stays present but is ignored.
  - The counter changes only by LOAD or KEY steps.

## Test plan
Bench parameters: CLK_HZ=8, TICK_HZ=1 (P=8), DEBOUNCE_CYCLES=4.
- Reset:
  - Stimulus: assert RESET_N low asynchronously mid-cycle with COUNT=7.
  - Required response: COUNT=0 and WRAP=0 immediately; after release, COUNT stays 0 with no inputs active.
- Debounced step:
  - Stimulus: DIR=1, KEY_STEP held low 20 cycles.
  - Required response: COUNT 0→1 exactly on edge 7; no further change.
  - Stimulus: 3-cycle low glitch.
  - Required response: COUNT unchanged.
- Load and priority:
  - Stimulus: SW=0xE, LOAD pulse, plus a KEY press debounced so its step coincides with LOAD.
  - Required response: COUNT=0xE and the step is discarded.
- Wrap:
  - Stimulus: from COUNT=0xF, DIR=1, one press.
  - Required response: COUNT=0 and a single-cycle WRAP.
  - Stimulus: DIR=0, one press.
  - Required response: COUNT=0xF and a WRAP pulse.
- Auto-count (AUTO_COUNT_EN):
  - Stimulus: RUN=1, DIR=1 from COUNT=0.
  - Required response: COUNT=1 on edge 11, 2 on edge 19.
  - Stimulus: step and tick coinciding.
  - Required response: +1 only.
  - Stimulus: build without the macro, RUN=1 for 40 cycles.
  - Required response: COUNT unchanged.
